// File: rtl/bht_predictor.sv
// Branch history table of saturating counters, swept to weakly-not-taken after reset.
// Optional gshare indexing and speculative global history under macro BHT_GSHARE_EN.
module bht_predictor #(
  parameter int IDX_W = 10,
  parameter int CTR_W = 2,
  parameter int GHR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_taken_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  output logic             ready_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic [GHR_W-1:0] upd_ghr_i
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [CTR_W-1:0] lk_ctr, up_ctr, up_ctr_nxt;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_dat;

  logic [CTR_W-1:0] ctr_tbl [ENTRIES];

  logic unused_pc;
  assign unused_pc = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0],
                       upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ready_o    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + IDX_ONE;
        if (init_idx_q == IDX_LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        ready_o = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign lk_idx     = pred_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign up_idx     = upd_pc_i[IDX_W+1:2] ^ IDX_W'(upd_ghr_i);
  assign pred_ghr_o = ghr_q;

  // A mispredict repair wins over the speculative shift of the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (ready_o) begin
      if (upd_valid_i && upd_mispredict_i) begin
        ghr_d = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
      end else if (pred_valid_i) begin
        ghr_d = {ghr_q[GHR_W-2:0], pred_taken_o};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic unused_gshare;
  assign unused_gshare = ^{upd_ghr_i, upd_mispredict_i};

  assign lk_idx     = pred_pc_i[IDX_W+1:2];
  assign up_idx     = upd_pc_i[IDX_W+1:2];
  assign pred_ghr_o = '0;
`endif

  // Reads are combinational and the write lands at the edge, so a same-cycle
  // lookup of the updated entry observes the old counter.
  assign lk_ctr       = ctr_tbl[lk_idx];
  assign up_ctr       = ctr_tbl[up_idx];
  assign pred_taken_o = ready_o & pred_valid_i & lk_ctr[CTR_W-1];

  always_comb begin
    up_ctr_nxt = up_ctr;
    if (upd_taken_i) begin
      if (up_ctr != CTR_MAX) begin
        up_ctr_nxt = up_ctr + CTR_ONE;
      end
    end else begin
      if (up_ctr != '0) begin
        up_ctr_nxt = up_ctr - CTR_ONE;
      end
    end
  end

  // While reset is held the FSM sits in INIT, so only the sweep may write.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = up_idx;
    wr_dat = up_ctr_nxt;
    if (state_q == ST_INIT) begin
      wr_en  = 1'b1;
      wr_idx = init_idx_q;
      wr_dat = CTR_INIT;
    end else if (upd_valid_i) begin
      wr_en  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      ctr_tbl[wr_idx] <= wr_dat;
    end
  end

endmodule
